iq_stream_packer: RTL



---
 rtl/iq_stream_packer_if.sv | 10 +
 rtl/iq_stream_packer.sv | 117 +++++++++++
 2 files changed

// File: rtl/iq_stream_packer_if.sv
// AXI4-Stream link carrying packed I/Q words from the packer toward the host DMA.
interface iq_stream_packer_if;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
    modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, output m_tready);
endinterface

// File: rtl/iq_stream_packer.sv
// Packs DDC I/Q samples into {Q,I} words, frames fixed-length packets at write time,
// and buffers them in a FIFO with a first-word-fall-through AXI-Stream output register.
module iq_stream_packer #(
    parameter int DEPTH = 64,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                in_valid,
    input  logic signed [15:0]  in_i,
    input  logic signed [15:0]  in_q,
    input  logic [15:0]         pkt_len_m1,
    iq_stream_packer_if.master  m,
    output logic [LW-1:0]       level,
    output logic                overflow,
    output logic [15:0]         drop_cnt,
    input  logic                overflow_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [15:0]   wcnt;
    logic [15:0]   len_l;
    logic [15:0]   len_cur;
    logic          last_w;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic          pop;
    logic          load;
    logic [LW-1:0] mem_cnt;
    logic          out_valid;
    logic          out_last;
    logic [31:0]   out_data;

    // full comes from the registered level only, so a same-cycle pop never admits a write
    always_comb begin
        full    = (level == LW'(DEPTH));
        wr_en   = in_valid && enable && !full;
        drop    = in_valid && enable && full;
        pop     = out_valid && m.m_tready;
        mem_cnt = level - LW'(out_valid);
        load    = (!out_valid || pop) && (mem_cnt != '0);
        len_cur = (wcnt == '0) ? pkt_len_m1 : len_l;
        last_w  = (wcnt == len_cur);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= {last_w, in_q, in_i};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            wcnt  <= '0;
            len_l <= '0;
        end else if (wr_en) begin
            wptr <= wptr + AW'(1);
            if (wcnt == '0) begin
                len_l <= pkt_len_m1;
            end
            wcnt <= last_w ? '0 : wcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            rptr      <= rptr + AW'(1);
            out_valid <= 1'b1;
            {out_last, out_data} <= mem[rptr];
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else begin
            unique case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // a drop coinciding with a clear leaves exactly one drop on record
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (overflow_clr) begin
            overflow <= drop;
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign m.m_tvalid = out_valid;
    assign m.m_tlast  = out_last;
    assign m.m_tdata  = out_data;
endmodule
